// File: rtl/registers_istr_mc_if.sv
// Host-side bundle of the multi-source ISTR block:
// event sources, FIFO flags, mask, read strobe and outputs.
interface registers_istr_mc_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0] SRC_I;
    logic            FIFOEMPTY;
    logic            FIFOFULL;
    logic            INTENA;
    logic            MASK_WR;
    logic [NSRC-1:0] MASK_DI;
    logic            ISTR_RD_;
    logic            CLR_INT;
    logic [NSRC+3:0] ISTR_O;
    logic [NSRC-1:0] MASK_O;
    logic            INT_O_;

    modport master (
        output SRC_I, FIFOEMPTY, FIFOFULL, INTENA,
        output MASK_WR, MASK_DI, ISTR_RD_, CLR_INT,
        input  ISTR_O, MASK_O, INT_O_
    );

    modport slave (
        input  SRC_I, FIFOEMPTY, FIFOFULL, INTENA,
        input  MASK_WR, MASK_DI, ISTR_RD_, CLR_INT,
        output ISTR_O, MASK_O, INT_O_
    );
endinterface

// File: rtl/registers_istr_mc.sv
// Multi-source interrupt status register with per-source mask,
// read-stable snapshot and optional clear-on-read. Falling-edge clocked.
module registers_istr_mc #(
    parameter int          NSRC        = 4,
    parameter logic [15:0] EDGE_MASK   = 16'h000F,
    parameter bit          CLR_ON_READ = 1'b1
) (
    input logic CLK,
    input logic RESET_,
    registers_istr_mc_if.slave bus
);
    localparam logic [NSRC-1:0] EM = EDGE_MASK[NSRC-1:0];

    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] r_snap_pend;
    logic            r_rd_q;
    logic            r_snap_f;
    logic            r_snap_p;
    logic            r_snap_ff;
    logic            r_snap_fe;
    logic            r_int_n;

    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_pend_nxt;
    logic            w_rd_end;
    logic            w_snap_ld;
    logic            w_int_f;
    logic            w_int_p;

    assign w_set    = bus.SRC_I & ~r_src_q & EM;
    assign w_rd_end = bus.ISTR_RD_ & ~r_rd_q;
    assign w_clr    = (bus.CLR_INT ? EM : '0)
                    | ((CLR_ON_READ && w_rd_end) ? (r_snap_pend & EM) : '0);

    // New edges are OR-ed in after the clear so a same-edge set survives.
    assign w_pend_nxt = (((r_pend & ~w_clr) | w_set) & EM)
                      | (bus.SRC_I & ~EM);

    assign w_int_f   = |r_pend;
    assign w_int_p   = bus.INTENA & (|(r_pend & r_mask));
    assign w_snap_ld = bus.ISTR_RD_ | r_rd_q;

    always_ff @(negedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            r_pend      <= '0;
            r_mask      <= '0;
            r_src_q     <= '0;
            r_rd_q      <= 1'b1;
            r_snap_pend <= '0;
            r_snap_f    <= 1'b0;
            r_snap_p    <= 1'b0;
            r_snap_ff   <= 1'b0;
            r_snap_fe   <= 1'b1;
            r_int_n     <= 1'b1;
        end else begin
            r_pend  <= w_pend_nxt;
            r_src_q <= bus.SRC_I;
            r_rd_q  <= bus.ISTR_RD_;
            r_int_n <= ~w_int_p;
            if (bus.MASK_WR) begin
                r_mask <= bus.MASK_DI;
            end
            // Snapshot freezes from the edge after read start until read end.
            if (w_snap_ld) begin
                r_snap_pend <= r_pend;
                r_snap_f    <= w_int_f;
                r_snap_p    <= w_int_p;
                r_snap_ff   <= bus.FIFOFULL;
                r_snap_fe   <= bus.FIFOEMPTY;
            end
        end
    end

    assign bus.ISTR_O = {r_snap_f, r_snap_p, r_snap_pend, r_snap_ff, r_snap_fe};
    assign bus.MASK_O = r_mask;
    assign bus.INT_O_ = r_int_n;
endmodule

// File: tb/tb_registers_istr_mc.sv
// Directed bench for registers_istr_mc: sources 0-2 edge, source 3 level.
// Inputs change and outputs are sampled 1ns after each falling edge.
module tb_registers_istr_mc;
    logic CLK;
    logic RESET_;
    int   n_tests;
    int   n_fail;

    registers_istr_mc_if #(.NSRC(4)) bus ();

    registers_istr_mc #(
        .NSRC        (4),
        .EDGE_MASK   (16'h0007),
        .CLR_ON_READ (1'b1)
    ) dut (
        .CLK    (CLK),
        .RESET_ (RESET_),
        .bus    (bus.slave)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        RESET_        = 1'b0;
        bus.SRC_I     = 4'b0000;
        bus.FIFOEMPTY = 1'b0;
        bus.FIFOFULL  = 1'b0;
        bus.INTENA    = 1'b0;
        bus.MASK_WR   = 1'b0;
        bus.MASK_DI   = 4'b0000;
        bus.ISTR_RD_  = 1'b1;
        bus.CLR_INT   = 1'b0;
        tick();
        tick();
        check("rst_istr", 32'(bus.ISTR_O), 32'h01);
        RESET_ = 1'b1;
        #1;
        check("rel_istr", 32'(bus.ISTR_O), 32'h01);
        check("rel_int", 32'(bus.INT_O_), 32'h1);
        check("rel_mask", 32'(bus.MASK_O), 32'h0);

        // Edge source 0 with enable
        bus.MASK_WR = 1'b1;
        bus.MASK_DI = 4'b0001;
        bus.INTENA  = 1'b1;
        tick();
        bus.MASK_WR = 1'b0;
        check("mask_rd", 32'(bus.MASK_O), 32'h1);
        bus.SRC_I = 4'b0001;
        tick();
        bus.SRC_I = 4'b0000;
        check("set_int_lat", 32'(bus.INT_O_), 32'h1);
        check("set_istr_lat", 32'(bus.ISTR_O), 32'h00);
        tick();
        check("set_int", 32'(bus.INT_O_), 32'h0);
        check("set_istr", 32'(bus.ISTR_O), 32'hC4);

        // Clear-on-read with mid-read event on source 1
        bus.MASK_WR = 1'b1;
        bus.MASK_DI = 4'b0011;
        tick();
        bus.MASK_WR  = 1'b0;
        bus.ISTR_RD_ = 1'b0;
        tick();
        bus.SRC_I = 4'b0010;
        tick();
        bus.SRC_I = 4'b0000;
        tick();
        check("rd_frozen", 32'(bus.ISTR_O), 32'hC4);
        bus.ISTR_RD_ = 1'b1;
        tick();
        tick();
        check("rd_end_istr", 32'(bus.ISTR_O), 32'hC8);
        check("rd_end_int", 32'(bus.INT_O_), 32'h0);

        // CLR_INT colliding with a source 2 edge
        bus.SRC_I   = 4'b0100;
        bus.CLR_INT = 1'b1;
        tick();
        bus.SRC_I    = 4'b0000;
        bus.CLR_INT  = 1'b0;
        bus.FIFOFULL = 1'b1;
        check("clr_int_lat", 32'(bus.INT_O_), 32'h0);
        tick();
        check("clr_istr", 32'(bus.ISTR_O), 32'h92);
        check("clr_int", 32'(bus.INT_O_), 32'h1);

        // Level source 3, masked then unmasked
        bus.FIFOFULL = 1'b0;
        bus.SRC_I    = 4'b1000;
        tick();
        tick();
        check("lvl_istr", 32'(bus.ISTR_O), 32'hB0);
        check("lvl_int", 32'(bus.INT_O_), 32'h1);
        bus.ISTR_RD_ = 1'b0;
        tick();
        bus.ISTR_RD_ = 1'b1;
        tick();
        bus.CLR_INT = 1'b1;
        tick();
        bus.CLR_INT = 1'b0;
        tick();
        check("lvl_kept", 32'(bus.ISTR_O), 32'hA0);
        check("lvl_masked", 32'(bus.INT_O_), 32'h1);
        bus.MASK_WR = 1'b1;
        bus.MASK_DI = 4'b1000;
        tick();
        bus.MASK_WR = 1'b0;
        check("mwr_mask", 32'(bus.MASK_O), 32'h8);
        check("mwr_int_lat", 32'(bus.INT_O_), 32'h1);
        tick();
        check("mwr_int", 32'(bus.INT_O_), 32'h0);
        check("mwr_istr", 32'(bus.ISTR_O), 32'hE0);

        // Reset in the middle of a read
        bus.SRC_I = 4'b1111;
        tick();
        bus.ISTR_RD_ = 1'b0;
        tick();
        check("all_istr", 32'(bus.ISTR_O), 32'hFC);
        check("all_int", 32'(bus.INT_O_), 32'h0);
        RESET_        = 1'b0;
        bus.SRC_I     = 4'b0000;
        bus.FIFOFULL  = 1'b1;
        #1;
        check("mid_rst_int", 32'(bus.INT_O_), 32'h1);
        check("mid_rst_istr", 32'(bus.ISTR_O), 32'h01);
        check("mid_rst_mask", 32'(bus.MASK_O), 32'h0);
        RESET_ = 1'b1;
        tick();
        check("fresh_load", 32'(bus.ISTR_O), 32'h02);
        bus.FIFOFULL = 1'b0;
        tick();
        check("fresh_frozen", 32'(bus.ISTR_O), 32'h02);
        bus.ISTR_RD_ = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
